rng_arbiter: RTL
================

# rng_arbiter

Round-robin arbiter sharing one 128-bit test RNG among NREQ consumers, e.g. salt/seed generation and masking units. It sequences the RNG's `update` strobe, captures the word the RNG registers one cycle later, and delivers it to exactly one requester with a one-cycle grant pulse. Each delivered word is fresh, and no two requesters ever receive the same word. The block sits between the RNG instance and the signing/keygen control FSMs.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 128, RNG word width; must match the RNG's TRN output
- clk  input  1  clock
- rst  input  1  reset: asynchronous, active-low
- req  input  NREQ  per-requester request level; held high until the matching gnt bit pulses
- gnt  output  NREQ  one-hot grant pulse, one cycle; rnd_data is valid in the same cycle
- rnd_data  output  W  registered random word; holds the last delivered value until the next delivery
- rng_update  output  1  update strobe to the RNG
- rng_trn  input  W  RNG registered output
- health_err  output  1  sticky repetition-test failure flag (RNG_ARB_HEALTH_EN only)

## Operation
- FSM states:
  - IDLE: if `|req`, pick a winner with round-robin starting at ptr, latch its index to win, go to UPD. Otherwise stay in IDLE.
  - UPD: assert rng_update for exactly one cycle, go to CAP. The RNG presents the new word on rng_trn in the next cycle.
  - CAP: register rnd_data <= rng_trn, gnt <= onehot(win), ptr <= win+1 mod NREQ, go to IDLE.
- gnt and rnd_data are registered: the gnt pulse appears in the cycle after CAP, together with the new rnd_data.
- Round-robin rule: the winner is the first set req bit at index ptr, ptr+1, ... wrapping modulo NREQ.
- A requester may not deassert req before its grant. If it does, the grant is still issued to it and the word is consumed.
- A req bit that is still high in the gnt cycle is a new request. It is arbitrated normally and gets no priority.
- Reset values: state IDLE, ptr 0, win 0, gnt 0, rng_update 0, rnd_data 0, health_err 0.
- Reset asserted mid-sequence aborts the sequence immediately. No gnt is issued and no further update is driven.

## Timing
- Cycle t (IDLE) sees req. Cycle t+1: rng_update=1. Cycle t+2: CAP. Cycle t+3: gnt high, rnd_data valid.
- Request-to-grant latency is 3 cycles for an uncontended request.
- Peak throughput is one word per 3 cycles. IDLE is re-entered in the gnt cycle, so back-to-back requests are sampled the same cycle gnt pulses.
- rng_update is never asserted outside UPD and never for two consecutive cycles.

## Configuration
- RNG_ARB_HEALTH_EN defined:
  - The block keeps a W-bit register prev (reset 0) holding the last captured word.
  - In CAP, if rng_trn == prev: set health_err (sticky until reset), issue no gnt, go back to UPD to retry. prev is unchanged.
  - Otherwise deliver the word as normal and set prev <= rng_trn.
- RNG_ARB_HEALTH_EN undefined: the prev register and the comparison are absent. health_err is tied to 0 and every captured word is delivered.

## Structure
- The shared package rng_arb_pkg holds:
  - the state enum (IDLE, UPD, CAP);
  - the ptr/win index width localparam, $clog2(NREQ);
  - the default W.
- Sub-module rr_pick is combinational: inputs req and ptr, outputs win index and any flag. It is reusable by other arbiters in the design.

## Test plan
- Single requester: req=4'b0001 held, RNG model output known. Expect rng_update at t+1, gnt=0001 at t+3, rnd_data equal to the RNG word, then req dropped.
- Contention: req=4'b1111 held continuously. Grants arrive in order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart, each with a distinct rnd_data.
- Fairness: after a grant to index 2 (ptr=3), assert req=4'b1001. Expect a grant to 3 first, then to 0.
- Reset mid-operation: drop rst during UPD. Expect gnt=0, rng_update=0 and rnd_data=0 immediately. After release, the first grant comes 3 cycles after req is sampled.
- Health check (macro on): RNG stub returns a constant word 0x5A…5A. Expect the first word delivered, then health_err=1 and no further gnt while the stub stays constant. Changing the stub word resumes grants; health_err stays 1 until reset.
- Macro off: the same constant stub yields a grant every 3 cycles and health_err stays 0.

Source files
------------

// File: rtl/rng_arb_pkg.sv
// ---------------------------------------------------------------------------
// rng_arb_pkg
// Shared definitions for the RNG arbiter slice: FSM state encoding, default
// sizes and the index-width helper used by rng_arbiter and rr_pick.
// ---------------------------------------------------------------------------
package rng_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    CAP  = 2'd2
  } state_t;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned IDX_W    = $clog2(DEF_NREQ);
  localparam int unsigned DEF_W    = 128;

  // Index width for an arbitrary requester count (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set request bit at
// index ptr, ptr+1, ... wrapping modulo NREQ.
// Ports:
//   i_req  [NREQ-1:0]  request vector
//   i_ptr  [IW-1:0]    starting index (must be < NREQ)
//   o_win  [IW-1:0]    winning index (0 when no request)
//   o_any              at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
  import rng_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_win,
  output logic            o_any
);

  logic [IW-1:0] w_win;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    w_win = '0;
    for (int unsigned off = NREQ; off > 0; off--) begin
      int unsigned idx;
      idx = (32'(i_ptr) + off - 1) % NREQ;
      if (i_req[IW'(idx)]) begin
        w_win = IW'(idx);
      end
    end
  end

  assign o_win = w_win;
  assign o_any = |i_req;

endmodule

// File: rtl/rng_arbiter.sv
// ---------------------------------------------------------------------------
// rng_arbiter
// Round-robin arbiter sharing one W-bit test RNG among NREQ consumers.
// Sequences the RNG update strobe, captures the word the RNG registers one
// cycle later and delivers it to exactly one requester with a one-cycle
// grant pulse. Request-to-grant latency is 3 cycles.
// Optional feature macro: RNG_ARB_HEALTH_EN (repetition test with retry and
// sticky health_err). Undefined: health_err tied to 0.
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   req         [NREQ-1:0] request levels, held until granted
//   gnt         [NREQ-1:0] one-hot grant pulse, rnd_data valid same cycle
//   rnd_data    [W-1:0]    last delivered random word
//   rng_update  update strobe to the RNG
//   rng_trn     [W-1:0]    RNG registered output
//   health_err  sticky repetition-test failure flag
// ---------------------------------------------------------------------------
module rng_arbiter
  import rng_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    rnd_data,
  output logic            rng_update,
  input  logic [W-1:0]    rng_trn,
  output logic            health_err
);

  localparam int unsigned IW = idx_width(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win;
  logic [NREQ-1:0] r_gnt;
  logic            r_upd;
  logic [W-1:0]    r_data;
`ifdef RNG_ARB_HEALTH_EN
  logic [W-1:0]    r_prev;
  logic            r_health;
`endif

  logic [IW-1:0]   w_win;
  logic            w_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_upd    <= 1'b0;
      r_data   <= '0;
`ifdef RNG_ARB_HEALTH_EN
      r_prev   <= '0;
      r_health <= 1'b0;
`endif
    end else begin
      // gnt and rng_update are single-cycle pulses by default.
      r_gnt <= '0;
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_win;
            r_upd   <= 1'b1;
            r_state <= UPD;
          end
        end
        UPD: begin
          r_state <= CAP;
        end
        CAP: begin
`ifdef RNG_ARB_HEALTH_EN
          if (rng_trn == r_prev) begin
            // Repeated word: flag it, withhold the grant and re-strobe.
            r_health <= 1'b1;
            r_upd    <= 1'b1;
            r_state  <= UPD;
          end else begin
            r_prev  <= rng_trn;
            r_data  <= rng_trn;
            r_gnt   <= NREQ'(1) << r_win;
            r_ptr   <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
            r_state <= IDLE;
          end
`else
          r_data  <= rng_trn;
          r_gnt   <= NREQ'(1) << r_win;
          r_ptr   <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
          r_state <= IDLE;
`endif
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rnd_data   = r_data;
  assign rng_update = r_upd;
`ifdef RNG_ARB_HEALTH_EN
  assign health_err = r_health;
`else
  assign health_err = 1'b0;
`endif

endmodule
